uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_counter.sv | 32 +++
 rtl/uart_tx_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity and
// stop-bit encodings, plus a small helper for parity decoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    // Encoding 2'b11 is reserved and behaves like "no parity".
    function automatic logic parity_enabled(input logic [1:0] par_type);
        return (par_type == PAR_ODD) || (par_type == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..div-1 while running and strobes o_bit_end
// on the last clock of each bit, wrapping to 0 so the next bit starts clean.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_run,
    input  logic                 i_restart,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_bit_end
);

    logic [DIV_WIDTH-1:0] r_count;
    logic                 w_last;

    // i_div is never zero here: the controller clamps it to at least 1.
    assign w_last    = (r_count == (i_div - DIV_WIDTH'(1)));
    assign o_bit_end = i_run && w_last && !i_restart;

    // Advance the count while a frame is in flight; wrap at the bit end.
    always_ff @(posedge clock) begin
        if (reset || i_restart) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= w_last ? '0 : (r_count + DIV_WIDTH'(1));
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte on a valid/ready handshake,
// latches it with its frame configuration and shifts start, data (LSB
// first), optional parity and one or two stop bits onto tx_out.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [1:0]            parity_type,
    input  logic                  stop_bits,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done_flag
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [1:0]            r_parity;
    logic                  r_stop_bits;
    logic                  r_par_bit;
    logic                  r_stop_cnt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_tx_out;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_bit_end;
    logic [DATA_WIDTH-1:0] w_shreg_next;
    logic [DIV_WIDTH-1:0]  w_div_clamped;

    assign tx_ready      = (r_state == IDLE) && !reset;
    assign w_accept      = tx_valid && tx_ready;
    assign w_shreg_next  = r_shreg >> 1;
    assign w_div_clamped = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;

    assign tx_out    = r_tx_out;
    assign busy      = r_busy;
    assign done_flag = r_done;

    uart_baud_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clock     (clock),
        .reset     (reset),
        .i_run     (r_busy),
        .i_restart (w_accept),
        .i_div     (r_div),
        .o_bit_end (w_bit_end)
    );

    // Frame sequencer: tx_out is registered alongside the state so the line
    // changes exactly on bit boundaries without a combinational decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_idx   <= '0;
            r_parity    <= PAR_NONE;
            r_stop_bits <= STOP_ONE;
            r_par_bit   <= 1'b0;
            r_stop_cnt  <= 1'b0;
            r_div       <= DIV_WIDTH'(1);
            r_tx_out    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg     <= tx_data;
                        r_parity    <= parity_type;
                        r_stop_bits <= stop_bits;
                        r_div       <= w_div_clamped;
                        // Even parity is the XOR of the data bits; odd inverts it.
                        r_par_bit   <= (^tx_data) ^ (parity_type == PAR_ODD);
                        r_bit_idx   <= '0;
                        r_stop_cnt  <= 1'b0;
                        r_tx_out    <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx_out <= r_shreg[0];
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shreg <= w_shreg_next;
                        if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                            if (parity_enabled(r_parity)) begin
                                r_tx_out <= r_par_bit;
                                r_state  <= PARITY;
                            end else begin
                                r_tx_out <= 1'b1;
                                r_state  <= STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_tx_out  <= w_shreg_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_tx_out <= 1'b1;
                        r_state  <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if ((r_stop_bits == STOP_TWO) && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_tx_out <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus pushes the expected per-cycle
// {tx_out, busy, done_flag, tx_ready} after each accept; a monitor pops and
// compares on every falling edge.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  tx_data = 8'h00;
    logic [1:0]  parity_type = PAR_NONE;
    logic        stop_bits = STOP_ONE;
    logic [15:0] baud_div = 16'd4;
    logic        tx_out;
    logic        busy;
    logic        done_flag;

    typedef struct {
        logic [3:0] v;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    localparam logic [3:0] E_DONE  = 4'b1011;
    localparam logic [3:0] E_IDLE  = 4'b1001;
    localparam logic [3:0] E_RHOLD = 4'b1000;

    uart_tx_ctrl #(
        .DATA_WIDTH (8),
        .DIV_WIDTH  (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .baud_div    (baud_div),
        .tx_out      (tx_out),
        .busy        (busy),
        .done_flag   (done_flag)
    );

    always #5 clock = ~clock;

    task automatic push(input logic [3:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Expand a hand-written bit string (first transmitted bit first) into
    // div busy cycles per bit, stopping after limit entries.
    task automatic push_bits(input string pat, input int div, input int limit, input string tag);
        int  n;
        logic b;
        n = 0;
        for (int i = 0; i < pat.len(); i++) begin
            b = (pat[i] == "1");
            for (int k = 0; k < div; k++) begin
                if (n < limit) begin
                    push({b, 3'b100}, $sformatf("%s[%0d]", tag, n));
                    n++;
                end
            end
        end
    endtask

    task automatic push_n(input logic [3:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) push(v, $sformatf("%s[%0d]", tag, i));
    endtask

    // Returns just after the accepting edge with tx_valid still high.
    task automatic start_frame(input logic [7:0] d, input logic [1:0] p,
                               input logic s, input logic [15:0] div);
        @(posedge clock);
        #1;
        tx_data     = d;
        parity_type = p;
        stop_bits   = s;
        baud_div    = div;
        tx_valid    = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input int max_cycles, input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max_cycles) begin
            @(posedge clock);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d expected cycles still pending, required 0",
                     tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare every cycle that has an expectation; otherwise the
    // controller must never emit a stray done_flag.
    always @(negedge clock) begin
        exp_t       e;
        logic [3:0] act;
        act = {tx_out, busy, done_flag, tx_ready};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: {tx_out,busy,done,ready} got %b required %b", e.tag, act, e.v);
            end
        end else if (mon_en) begin
            n_tests++;
            if (done_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_done: done_flag got %b required 0", done_flag);
            end
        end
    end

    initial begin
        // Reset held together with tx_valid: reset wins, no frame starts.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(posedge clock);
        #1;
        push_n(E_RHOLD, 2, "reset_hold");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        tx_valid = 1'b0;
        push_n(E_IDLE, 2, "after_reset");
        mon_en = 1'b1;
        wait_drain(20, "after_reset");

        // 0xA5, even parity (bit 0), one stop, 4 clocks/bit: done at 44.
        start_frame(8'hA5, PAR_EVEN, STOP_ONE, 16'd4);
        tx_valid = 1'b0;
        push_bits("01010010101", 4, 1000, "a5_even");
        push(E_DONE, "a5_even_done");
        push_n(E_IDLE, 1, "a5_even_idle");
        wait_drain(100, "a5_even");

        // 0xA5, odd parity (bit 1), two stop bits: done at 48.
        start_frame(8'hA5, PAR_ODD, STOP_TWO, 16'd4);
        tx_valid = 1'b0;
        push_bits("010100101111", 4, 1000, "a5_odd2");
        push(E_DONE, "a5_odd2_done");
        push_n(E_IDLE, 1, "a5_odd2_ready");
        wait_drain(100, "a5_odd2");

        // 0x00, no parity, baud_div 0 behaves as 1: nine lows, stop, done at 10.
        start_frame(8'h00, PAR_NONE, STOP_ONE, 16'd0);
        tx_valid = 1'b0;
        push_bits("0000000001", 1, 1000, "div0");
        push(E_DONE, "div0_done");
        push_n(E_IDLE, 2, "div0_idle");
        wait_drain(50, "div0");

        // Back-to-back 0x3C then 0xC3 with tx_valid held; inputs changed
        // mid-frame must not disturb the first frame.
        start_frame(8'h3C, PAR_NONE, STOP_ONE, 16'd2);
        push_bits("0001111001", 2, 1000, "b2b_3c");
        push(E_DONE, "b2b_3c_done");
        push_bits("0110000111", 2, 1000, "b2b_c3");
        push(E_DONE, "b2b_c3_done");
        push_n(E_IDLE, 2, "b2b_idle");
        repeat (4) @(posedge clock);
        #1;
        tx_data     = 8'hC3;
        baud_div    = 16'd5;
        parity_type = PAR_EVEN;
        repeat (6) @(posedge clock);
        #1;
        baud_div    = 16'd2;
        parity_type = PAR_NONE;
        repeat (11) @(posedge clock);
        #1;
        tx_valid = 1'b0;
        wait_drain(100, "b2b");

        // Reset during DATA bit 3 of 0xA5: immediate idle, no done_flag.
        start_frame(8'hA5, PAR_NONE, STOP_ONE, 16'd4);
        tx_valid = 1'b0;
        push_bits("0101001011", 4, 18, "rst_pre");
        repeat (17) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_n(E_IDLE, 3, "rst_post");
        wait_drain(20, "rst_post");

        // Fresh 0x55 after the abort, even parity (bit 0), 3 clocks/bit.
        start_frame(8'h55, PAR_EVEN, STOP_ONE, 16'd3);
        tx_valid = 1'b0;
        push_bits("01010101001", 3, 1000, "x55");
        push(E_DONE, "x55_done");
        push_n(E_IDLE, 1, "x55_idle");
        wait_drain(100, "x55");

        // tx_valid pulsed mid-frame is ignored: timing intact, no extra frame.
        start_frame(8'h0F, PAR_EVEN, STOP_TWO, 16'd2);
        tx_valid = 1'b0;
        push_bits("011110000011", 2, 1000, "pulse");
        push(E_DONE, "pulse_done");
        push_n(E_IDLE, 3, "pulse_idle");
        repeat (5) @(posedge clock);
        #1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
        wait_drain(100, "pulse");

        repeat (3) @(posedge clock);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
